// File: rtl/toggle_pkg.sv
// Shared defaults and sizing helper for the toggle-channel receiver.
package toggle_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 2;
    localparam int SYNC_DEF  = 2;
    localparam int CW_DEF    = 16;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/toggle_rx_fifo.sv
// Small FIFO with a registered head word. The head holds its last value once the FIFO drains.
module toggle_rx_fifo
    import toggle_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full
);

    localparam int AW = ptr_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [AW:0]   occ_q, occ_d;
    logic [DW-1:0] head_q, head_d;
    logic          do_wr, do_rd;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A full FIFO still accepts a write when the head pops on the same edge.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_next = rd_ptr_q + AW'(1);
    assign rd_data = head_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        occ_d    = occ_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        head_d   = head_q;
        if (do_rd && (occ_q > (AW+1)'(1))) begin
            head_d = mem_q[rd_next];
        end else if (do_wr && (empty || do_rd)) begin
            head_d = wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
        end
    end

    // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/toggle_rx.sv
// Receiving end of a two-phase toggle event channel: synchronise, capture, acknowledge,
// and present captured words on a valid/ready interface.
module toggle_rx
    import toggle_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF,
    parameter int CW          = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_tog,
    input  logic [DW-1:0] req_data,
    output logic          ack_tog,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] evt_count,
    output logic          overrun
);

    logic          req_s;
    logic          req_s_d_q;
    logic          ack_q, ack_d;
    logic [CW-1:0] evt_q, evt_d;
    logic          overrun_q, overrun_d;
    logic          wr_en_prev_q;
    logic          pending, wr_en, rd_en;
    logic          fifo_empty, fifo_full;

    if (SYNC_STAGES == 0) begin : g_direct
        assign req_s = req_tog;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= req_tog;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end
        assign req_s = sync_q[SYNC_STAGES-1];
    end

    assign pending = (req_s != ack_q);
    assign rd_en   = out_ready && !fifo_empty;
    assign wr_en   = pending && (!fifo_full || rd_en);

    always_comb begin
        ack_d     = ack_q ^ wr_en;
        evt_d     = evt_q + CW'(wr_en);
        // A fresh edge while the previous event is still unacknowledged means the sender broke protocol.
        overrun_d = overrun_q
                  | ((req_s != req_s_d_q) && (req_s_d_q != ack_q) && !wr_en_prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_s_d_q    <= 1'b0;
            ack_q        <= 1'b0;
            evt_q        <= '0;
            overrun_q    <= 1'b0;
            wr_en_prev_q <= 1'b0;
        end else begin
            req_s_d_q    <= req_s;
            ack_q        <= ack_d;
            evt_q        <= evt_d;
            overrun_q    <= overrun_d;
            wr_en_prev_q <= wr_en;
        end
    end

    toggle_rx_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (req_data),
        .rd_en   (rd_en),
        .rd_data (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign ack_tog   = ack_q;
    assign out_valid = !fifo_empty;
    assign evt_count = evt_q;
    assign overrun   = overrun_q;

endmodule
